// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter sequencer: next-PC select
// codes, the run/halt state encoding, the default reset address and the
// branch-offset helper.
package pc_pkg;

  typedef enum logic [1:0] {
    NPC_SEQ = 2'b00,
    NPC_BR  = 2'b01,
    NPC_J   = 2'b10,
    NPC_JR  = 2'b11
  } npc_sel_e;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } pc_state_e;

  localparam logic [31:0] PC_RESET_ADDR = 32'h0000_0000;

  // Branch word offset: sign-extend and scale to a byte offset.
  function automatic logic [31:0] br_offset(input logic [15:0] imm16);
    return {{14{imm16[15]}}, imm16, 2'b00};
  endfunction

endpackage

// File: rtl/pc_tick_gen.sv
// Advance-tick divider: counts 0..TICK_DIV-1 and asserts tick for one
// cycle at the terminal count. TICK_DIV=1 gives a tick every cycle.
module pc_tick_gen #(
  parameter int unsigned TICK_DIV = 25_000_000
) (
  input  logic Clk,
  input  logic Rst,
  output logic tick
);

  localparam logic [31:0] LAST_CNT = TICK_DIV - 32'd1;

  logic [31:0] count_q, count_d;

  assign tick = (count_q == LAST_CNT);

  // Wrap to zero at the terminal count, otherwise increment.
  always_comb begin
    count_d = tick ? 32'd0 : count_q + 32'd1;
  end

  // Counter register; reset restarts the tick period from zero.
  always_ff @(posedge Clk) begin
    if (Rst) count_q <= 32'd0;
    else     count_q <= count_d;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer. Advances PC on each update strobe (divided
// tick, or a debounced Step edge when PC_STEP_EN is defined), selecting
// sequential, branch, jump or jump-register targets. A misaligned target
// halts the sequencer with a sticky AlignErr until reset.
// Build option: PC_STEP_EN -- Step rising edge replaces the divided tick.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter logic [31:0] RESET_ADDR = PC_RESET_ADDR,
  parameter int unsigned TICK_DIV   = 25_000_000
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Stall,
  input  logic [1:0]  NPCSel,
  input  logic        BrTaken,
  input  logic [15:0] Imm16,
  input  logic [25:0] Imm26,
  input  logic [31:0] RegAddr,
  input  logic        Step,
  output logic [31:0] PC,
  output logic [31:0] PCPlus4,
  output logic        Valid,
  output logic        AlignErr
);

  logic        strobe;
  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;
  logic [31:0] next_pc;
  logic        misaligned;
  logic        pc_load, halt_set;
  pc_state_e   state_q, state_d;

`ifdef PC_STEP_EN
  logic step_s1_q, step_s2_q, step_prev_q;

  // Two-flop synchronizer followed by a previous-value flop for edge detect.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      step_s1_q   <= 1'b0;
      step_s2_q   <= 1'b0;
      step_prev_q <= 1'b0;
    end else begin
      step_s1_q   <= Step;
      step_s2_q   <= step_s1_q;
      step_prev_q <= step_s2_q;
    end
  end

  // A held button yields a single strobe on its synchronized rising edge.
  assign strobe = step_s2_q & ~step_prev_q;

  localparam int unsigned UNUSED_TICK_DIV = TICK_DIV;
`else
  pc_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .Clk  (Clk),
    .Rst  (Rst),
    .tick (strobe)
  );

  logic unused_step;
  assign unused_step = Step;
`endif

  assign PCPlus4 = pc_q + 32'd4;

  // Next-PC selection; all arithmetic wraps modulo 2^32.
  always_comb begin
    next_pc = PCPlus4;
    case (npc_sel_e'(NPCSel))
      NPC_SEQ: next_pc = PCPlus4;
      NPC_BR:  next_pc = BrTaken ? (PCPlus4 + br_offset(Imm16)) : PCPlus4;
      NPC_J:   next_pc = {PCPlus4[31:28], Imm26, 2'b00};
      NPC_JR:  next_pc = RegAddr;
      default: next_pc = PCPlus4;
    endcase
  end

  assign misaligned = (next_pc[1:0] != 2'b00);

  // State register.
  always_ff @(posedge Clk) begin
    if (Rst) state_q <= ST_RUN;
    else     state_q <= state_d;
  end

  // Next-state: an update toward a misaligned target halts; HALT is terminal.
  always_comb begin
    state_d = state_q;
    if (state_q == ST_RUN && strobe && !Stall && misaligned) state_d = ST_HALT;
  end

  // FSM outputs: load PC on a clean update, flag the error on a bad one.
  always_comb begin
    pc_load  = 1'b0;
    halt_set = 1'b0;
    if (state_q == ST_RUN && strobe && !Stall) begin
      if (misaligned) halt_set = 1'b1;
      else            pc_load  = 1'b1;
    end
  end

  // Datapath next values: Valid pulses once per load, AlignErr is sticky.
  always_comb begin
    pc_d    = pc_load ? next_pc : pc_q;
    valid_d = pc_load;
    err_d   = err_q | halt_set;
  end

  // PC, Valid and AlignErr registers.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      pc_q    <= RESET_ADDR;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign PC       = pc_q;
  assign Valid    = valid_q;
  assign AlignErr = err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer (TICK_DIV=4, RESET_ADDR=0x3000): directed
// scenarios plus randomized traffic checked against a behavioural model.
module tb_pc_sequencer;

  localparam logic [31:0] RA = 32'h0000_3000;
  localparam int          TD = 4;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        Stall = 1'b0;
  logic [1:0]  NPCSel = 2'b00;
  logic        BrTaken = 1'b0;
  logic [15:0] Imm16 = '0;
  logic [25:0] Imm26 = '0;
  logic [31:0] RegAddr = '0;
  logic        Step = 1'b0;
  logic [31:0] PC, PCPlus4;
  logic        Valid, AlignErr;

  int total = 0;
  int bad   = 0;

  // Model state
  logic [31:0] m_pc = RA;
  int          m_n = 0;
  bit          m_halt = 0, m_valid = 0, m_err = 0;

  always #5 Clk = ~Clk;

  pc_sequencer #(
    .RESET_ADDR (RA),
    .TICK_DIV   (TD)
  ) dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .Stall    (Stall),
    .NPCSel   (NPCSel),
    .BrTaken  (BrTaken),
    .Imm16    (Imm16),
    .Imm26    (Imm26),
    .RegAddr  (RegAddr),
    .Step     (Step),
    .PC       (PC),
    .PCPlus4  (PCPlus4),
    .Valid    (Valid),
    .AlignErr (AlignErr)
  );

  // Advance the model by one clock edge using the current inputs, then let
  // the DUT take the same edge and settle.
  task automatic cycle();
    logic [31:0]        tgt;
    logic signed [15:0] s16;
    int                 off;
    bit                 tick;
    if (Rst) begin
      m_pc = RA; m_n = 0; m_halt = 0; m_valid = 0; m_err = 0;
    end else begin
      tick = ((m_n % TD) == TD - 1);
      m_n++;
      m_valid = 0;
      if (!m_halt && tick && !Stall) begin
        s16 = Imm16;
        off = s16;
        case (NPCSel)
          2'd0: tgt = m_pc + 32'd4;
          2'd1: tgt = BrTaken ? m_pc + 32'd4 + 32'(off * 4) : m_pc + 32'd4;
          2'd2: tgt = ((m_pc + 32'd4) & 32'hF000_0000) | ({6'b0, Imm26} * 32'd4);
          default: tgt = RegAddr;
        endcase
        if ((tgt % 4) != 0) begin
          m_halt = 1; m_err = 1;
        end else begin
          m_pc = tgt; m_valid = 1;
        end
      end
    end
    @(posedge Clk);
    #1;
  endtask

  task automatic drive_idle();
    Stall   = 1'b0;
    NPCSel  = 2'b00;
    BrTaken = 1'($urandom);
    Imm16   = 16'($urandom);
    Imm26   = 26'($urandom);
    RegAddr = $urandom;
    Step    = 1'b0;
  endtask

  task automatic do_reset();
    Rst = 1'b1;
    cycle();
    Rst = 1'b0;
  endtask

  task automatic test_reset();
    drive_idle();
    Rst = 1'b1;
    cycle();
    cycle();
    Rst = 1'b0;
    total++; if (PC !== RA) begin bad++; $display("FAIL reset_pc: got %h want %h", PC, RA); end
    total++; if (Valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", Valid); end
    total++; if (AlignErr !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", AlignErr); end
    total++; if (PCPlus4 !== RA + 32'd4) begin bad++; $display("FAIL reset_pcplus4: got %h want %h", PCPlus4, RA + 32'd4); end
  endtask

  task automatic test_sequential();
    int nv = 0;
    logic [31:0] exp_pc;
    do_reset();
    drive_idle();
    for (int i = 1; i <= 12; i++) begin
      cycle();
      exp_pc = RA + 32'(4 * (i / TD));
      if (Valid === 1'b1) nv++;
      total++; if (PC !== exp_pc) begin bad++; $display("FAIL seq_pc[%0d]: got %h want %h", i, PC, exp_pc); end
      total++; if (Valid !== 1'((i % TD) == 0)) begin bad++; $display("FAIL seq_valid[%0d]: got %b want %b", i, Valid, (i % TD) == 0); end
      total++; if (PC !== m_pc) begin bad++; $display("FAIL seq_model[%0d]: got %h want %h", i, PC, m_pc); end
    end
    total++; if (nv != 3) begin bad++; $display("FAIL seq_valid_count: got %0d want 3", nv); end
  endtask

  task automatic test_branch_jump();
    do_reset();
    drive_idle();
    repeat (8) cycle();
    total++; if (PC !== 32'h3008) begin bad++; $display("FAIL bj_start: got %h want 00003008", PC); end
    NPCSel = 2'b01; BrTaken = 1'b1; Imm16 = 16'hFFFE;
    repeat (TD) cycle();
    total++; if (PC !== 32'h3004) begin bad++; $display("FAIL branch_back: got %h want 00003004", PC); end
    total++; if (Valid !== 1'b1) begin bad++; $display("FAIL branch_valid: got %b want 1", Valid); end
    BrTaken = 1'b0; Imm16 = 16'($urandom);
    repeat (TD) cycle();
    total++; if (PC !== 32'h3008) begin bad++; $display("FAIL branch_not_taken: got %h want 00003008", PC); end
    NPCSel = 2'b10; Imm26 = 26'h0000C00;
    repeat (TD) cycle();
    total++; if (PC !== 32'h0000_3000) begin bad++; $display("FAIL jump: got %h want 00003000", PC); end
    total++; if (PC !== m_pc) begin bad++; $display("FAIL jump_model: got %h want %h", PC, m_pc); end
  endtask

  task automatic test_stall_wrap();
    logic [31:0] pc0;
    bit saw_v = 0;
    pc0 = PC;
    drive_idle();
    Stall = 1'b1;
    repeat (TD) begin
      cycle();
      if (Valid === 1'b1) saw_v = 1;
    end
    Stall = 1'b0;
    total++; if (PC !== pc0) begin bad++; $display("FAIL stall_pc: got %h want %h", PC, pc0); end
    total++; if (saw_v) begin bad++; $display("FAIL stall_valid: got 1 want 0"); end
    NPCSel = 2'b11; RegAddr = 32'hFFFF_FFFC;
    repeat (TD) cycle();
    total++; if (PC !== 32'hFFFF_FFFC) begin bad++; $display("FAIL jr_top: got %h want fffffffc", PC); end
    total++; if (PCPlus4 !== 32'h0) begin bad++; $display("FAIL pcplus4_wrap: got %h want 00000000", PCPlus4); end
    NPCSel = 2'b00;
    repeat (TD) cycle();
    total++; if (PC !== 32'h0) begin bad++; $display("FAIL seq_wrap: got %h want 00000000", PC); end
    NPCSel = 2'b01; BrTaken = 1'b1; Imm16 = 16'hFFFC;
    repeat (TD) cycle();
    total++; if (PC !== 32'hFFFF_FFF4) begin bad++; $display("FAIL branch_wrap: got %h want fffffff4", PC); end
  endtask

  task automatic test_misalign();
    logic [31:0] pc0;
    do_reset();
    drive_idle();
    repeat (TD) cycle();
    pc0 = PC;
    NPCSel = 2'b11; RegAddr = 32'h0000_3002;
    repeat (TD) cycle();
    total++; if (PC !== pc0) begin bad++; $display("FAIL misalign_pc: got %h want %h", PC, pc0); end
    total++; if (AlignErr !== 1'b1) begin bad++; $display("FAIL misalign_err: got %b want 1", AlignErr); end
    total++; if (Valid !== 1'b0) begin bad++; $display("FAIL misalign_valid: got %b want 0", Valid); end
    for (int i = 0; i < 12; i++) begin
      Stall = 1'($urandom); NPCSel = 2'($urandom); BrTaken = 1'($urandom);
      Imm16 = 16'($urandom); Imm26 = 26'($urandom); RegAddr = $urandom & 32'hFFFF_FFFC;
      cycle();
      total++; if (PC !== pc0 || Valid !== 1'b0 || AlignErr !== 1'b1) begin
        bad++; $display("FAIL halt_hold[%0d]: got pc=%h v=%b e=%b want pc=%h v=0 e=1", i, PC, Valid, AlignErr, pc0);
      end
    end
    do_reset();
    total++; if (PC !== RA || AlignErr !== 1'b0) begin
      bad++; $display("FAIL halt_reset: got pc=%h e=%b want pc=%h e=0", PC, AlignErr, RA);
    end
    drive_idle();
    repeat (TD) cycle();
    total++; if (PC !== RA + 32'd4) begin bad++; $display("FAIL halt_recover: got %h want %h", PC, RA + 32'd4); end
  endtask

  task automatic test_reset_midcount();
    logic [31:0] exp_pc;
    do_reset();
    drive_idle();
    repeat (2) cycle();
    Rst = 1'b1;
    cycle();
    Rst = 1'b0;
    total++; if (PC !== RA) begin bad++; $display("FAIL mid_reset_pc: got %h want %h", PC, RA); end
    for (int i = 1; i <= TD; i++) begin
      cycle();
      exp_pc = (i == TD) ? RA + 32'd4 : RA;
      total++; if (PC !== exp_pc || Valid !== 1'(i == TD)) begin
        bad++; $display("FAIL mid_reset_latency[%0d]: got pc=%h v=%b want pc=%h v=%b", i, PC, Valid, exp_pc, i == TD);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      Rst     = ($urandom_range(0, 59) == 0);
      Stall   = ($urandom_range(0, 3) == 0);
      NPCSel  = 2'($urandom);
      BrTaken = 1'($urandom);
      Imm16   = 16'($urandom);
      Imm26   = 26'($urandom);
      RegAddr = ($urandom_range(0, 7) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
      cycle();
      total++; if (PC !== m_pc) begin bad++; $display("FAIL rand_pc[%0d]: got %h want %h", i, PC, m_pc); end
      total++; if (Valid !== m_valid) begin bad++; $display("FAIL rand_valid[%0d]: got %b want %b", i, Valid, m_valid); end
      total++; if (AlignErr !== m_err) begin bad++; $display("FAIL rand_err[%0d]: got %b want %b", i, AlignErr, m_err); end
      total++; if (PCPlus4 !== m_pc + 32'd4) begin bad++; $display("FAIL rand_pcplus4[%0d]: got %h want %h", i, PCPlus4, m_pc + 32'd4); end
    end
    Rst = 1'b0;
  endtask

`ifdef PC_STEP_EN
  task automatic test_step();
    do_reset();
    drive_idle();
    Step = 1'b1;
    repeat (20) cycle();
    Step = 1'b0;
    repeat (4) cycle();
    total++; if (PC !== RA + 32'd4) begin bad++; $display("FAIL step_held: got %h want %h", PC, RA + 32'd4); end
    do_reset();
    drive_idle();
    repeat (3) begin
      Step = 1'b1; repeat (3) cycle();
      Step = 1'b0; repeat (3) cycle();
    end
    total++; if (PC !== 32'h300C) begin bad++; $display("FAIL step_toggle: got %h want 0000300c", PC); end
    do_reset();
    drive_idle();
    Stall = 1'b1;
    Step = 1'b1; repeat (6) cycle();
    Step = 1'b0; repeat (3) cycle();
    Stall = 1'b0;
    total++; if (PC !== RA) begin bad++; $display("FAIL step_stall: got %h want %h", PC, RA); end
  endtask
`endif

  initial begin
    test_reset();
`ifdef PC_STEP_EN
    test_step();
`else
    test_sequential();
    test_branch_jump();
    test_stall_wrap();
    test_misalign();
    test_reset_midcount();
    test_random();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The block SHALL have parameter RESET_ADDR, default 32'h0000_0000, giving the PC value loaded on reset.
REQ-002 The block SHALL have parameter TICK_DIV, default 25_000_000, giving the Clk cycles per advance tick (legal range 1 to 2^32-1).
REQ-003 The block SHALL have port Clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-004 The block SHALL have port Rst, input, 1 bit: the reset, which is synchronous and active-high.
REQ-005 The block SHALL have port Stall, input, 1 bit: when high, it blocks a PC update on the current tick.
REQ-006 The block SHALL have port NPCSel, input, 2 bits: next-PC select (00 sequential, 01 branch, 10 jump, 11 jump-register).
REQ-007 The block SHALL have port BrTaken, input, 1 bit: the branch condition, used only when NPCSel=01.
REQ-008 The block SHALL have port Imm16, input, 16 bits: the branch word offset.
REQ-009 The block SHALL have port Imm26, input, 26 bits: the jump word index.
REQ-010 The block SHALL have port RegAddr, input, 32 bits: the jump-register target.
REQ-011 The block SHALL have port Step, input, 1 bit: the raw single-step button; it is ignored unless PC_STEP_EN is defined.
REQ-012 The block SHALL have port PC, output, 32 bits: the current program counter.
REQ-013 The block SHALL have port PCPlus4, output, 32 bits: combinational PC+4, modulo 2^32.
REQ-014 The block SHALL have port Valid, output, 1 bit: a one-cycle pulse in the cycle after each PC update.
REQ-015 The block SHALL have port AlignErr, output, 1 bit: a sticky misaligned-target flag.

Function
REQ-016 Tick counter: counts 0 to TICK_DIV-1 and wraps; tick=1 in the cycle where count==TICK_DIV-1; TICK_DIV=1 makes tick=1 every cycle.
REQ-017 Update condition: state==RUN, tick=1 and Stall=0; PC loads next-PC on that edge. A stalled tick is lost, and the counter keeps running.
REQ-018 Next-PC for NPCSel=00: PC+4.
REQ-019 Next-PC for NPCSel=01: PC+4+(sign-extended Imm16<<2) when BrTaken=1, otherwise PC+4.
REQ-020 Next-PC for NPCSel=10: {PCPlus4[31:28],Imm26,2'b00}.
REQ-021 Next-PC for NPCSel=11: RegAddr.
REQ-022 All next-PC arithmetic SHALL be 32-bit modulo 2^32: 32'hFFFF_FFFC+4 gives 0, and a negative offset below 0 wraps.
REQ-023 States are RUN and HALT. RUN goes to HALT on an update with a target where bits [1:0]!=0. In that case PC is not loaded, AlignErr is set, and Valid is not pulsed.
REQ-024 HALT: PC SHALL hold, Valid SHALL stay 0, and all inputs except Rst SHALL be ignored; only reset leaves HALT.
REQ-025 Valid SHALL be a registered pulse, high exactly one cycle after the updating edge.
REQ-026 Latency: PC SHALL reflect the new value in the cycle immediately after the updating edge.

Reset
REQ-027 While Rst=1 on an edge: PC=RESET_ADDR, tick counter=0, state=RUN, Valid=0, AlignErr=0, and step synchronizer/edge flops=0.
REQ-028 Rst SHALL dominate all simultaneous events (tick, Stall, misalignment, Step edge), including mid-count or in HALT.
REQ-029 The first tick after reset release SHALL occur TICK_DIV cycles after the release edge.

Configuration
REQ-030 Macro PC_STEP_EN. When defined, Step passes through a 2-flop synchronizer plus a rising-edge detector, and the detected edge replaces tick as the update strobe; the divider is not instantiated.
REQ-031 Without PC_STEP_EN, Step SHALL be unused and updates SHALL be driven by tick.
REQ-032 Under PC_STEP_EN, a held-high Step SHALL produce exactly one update, and Stall SHALL still block that update.

Structure
REQ-033 Package pc_pkg SHALL hold the NPCSel encodings (NPC_SEQ, NPC_BR, NPC_J, NPC_JR), the state encoding (ST_RUN, ST_HALT), and the default RESET_ADDR.
REQ-034 Sub-module pc_tick_gen SHALL implement the tick divider with ports Clk, Rst and tick.

Verification (bench uses TICK_DIV=4, RESET_ADDR=32'h0000_3000)
REQ-035 Sequential run: reset, then NPCSel=00 for 3 ticks -> PC goes 3000, 3004, 3008, 300C; Valid pulses every 4 cycles; no change between ticks.
REQ-036 Branch and jump: PC=3008 with NPCSel=01, BrTaken=1, Imm16=16'hFFFE -> PC=3004. Then NPCSel=10, Imm26=26'h0000C00 -> PC=0000_3000.
REQ-037 Stall and wrap: Stall=1 across one tick -> PC unchanged and no Valid. Force PC to FFFF_FFFC via jump-register with NPCSel=00 -> PC=0000_0000.
REQ-038 Misalignment: NPCSel=11 with RegAddr=32'h0000_3002 -> PC holds, AlignErr=1, state HALT. Further ticks -> no change. Rst -> PC=3000 and AlignErr=0.
REQ-039 Reset mid-count: assert Rst at count 2 of a tick -> PC=3000; next update occurs 4 cycles after release.
REQ-040 PC_STEP_EN build: Step held high for 20 cycles -> exactly one update. Step toggled 3 times -> PC=300C.
